// File: rtl/output_collector_fifo_pkg.sv
// Shared widths and frame geometry for the VGG16 output collector.
// Values here are the defaults picked up by the top level and its interface.
package vgg_out_pkg;

    localparam int DWIDTH       = 32;
    localparam int CWIDTH       = 4;
    localparam int WIDTH        = 56;
    localparam int HEIGHT       = 56;
    localparam int NUM_DATA     = WIDTH * HEIGHT;
    localparam int NUM_IMG      = 1;
    localparam int DEPTH        = 64;
    localparam int AFULL_MARGIN = 4;
    localparam int EWIDTH       = CWIDTH + DWIDTH;

endpackage

// File: rtl/output_collector_fifo_if.sv
// Result-stream and drain-side signals of the output collector.
// The master side is upstream plus host drain; the slave side is the collector.
interface output_collector_fifo_if
    import vgg_out_pkg::*;
#(
    parameter int DWIDTH = vgg_out_pkg::DWIDTH,
    parameter int CWIDTH = vgg_out_pkg::CWIDTH,
    parameter int DEPTH  = vgg_out_pkg::DEPTH
);
    localparam int UW = $clog2(DEPTH) + 1;

    logic [DWIDTH-1:0] data_in;
    logic              data_valid_in;
    logic [CWIDTH-1:0] class_in;
    logic              ready_out;
    logic              fifo_rdreq;
    logic [DWIDTH-1:0] fifo_data;
    logic [CWIDTH-1:0] image_class;
    logic              fifo_empty;
    logic [UW-1:0]     fifo_usedw;

    modport master (
        output data_in, data_valid_in, class_in, fifo_rdreq,
        input  ready_out, fifo_data, image_class, fifo_empty, fifo_usedw
    );

    modport slave (
        input  data_in, data_valid_in, class_in, fifo_rdreq,
        output ready_out, fifo_data, image_class, fifo_empty, fifo_usedw
    );

endinterface

// File: rtl/output_collector_fifo_sync_fifo_fwft.sv
// Show-ahead synchronous FIFO; callers pass only accepted read/write strobes.
// Head reads 0 while empty so stale storage never reaches the outputs.
module sync_fifo_fwft #(
    parameter int W     = 36,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   usedw
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign usedw   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/output_collector_fifo.sv
// Final VGG16 stage: tags result words with their frame class, counts
// pixels and frames, and buffers {class, data} entries for the host drain.
module output_collector_fifo
    import vgg_out_pkg::*;
#(
    parameter int DWIDTH       = vgg_out_pkg::DWIDTH,
    parameter int CWIDTH       = vgg_out_pkg::CWIDTH,
    parameter int WIDTH        = vgg_out_pkg::WIDTH,
    parameter int HEIGHT       = vgg_out_pkg::HEIGHT,
    parameter int NUM_IMG      = vgg_out_pkg::NUM_IMG,
    parameter int DEPTH        = vgg_out_pkg::DEPTH,
    parameter int AFULL_MARGIN = vgg_out_pkg::AFULL_MARGIN
) (
    input  logic                   clk,
    input  logic                   resetn,
    output_collector_fifo_if.slave bus,
    output logic                   frame_done,
    output logic                   all_done,
    output logic                   overflow
);
    localparam int ND = WIDTH * HEIGHT;
    localparam int EW = CWIDTH + DWIDTH;
    localparam int UW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(ND);
    localparam int IW = $clog2(NUM_IMG + 1);

    logic [PW-1:0]     pix_cnt;
    logic [IW-1:0]     img_cnt;
    logic [CWIDTH-1:0] class_reg;
    logic [CWIDTH-1:0] tag;
    logic              full, empty;
    logic              rd_acc, wr_acc;
    logic              first_px, last_px;
    logic [EW-1:0]     rd_data;
    logic [UW-1:0]     usedw;

    assign rd_acc   = bus.fifo_rdreq & ~empty;
    assign wr_acc   = bus.data_valid_in & ~all_done & (~full | rd_acc);
    assign first_px = (pix_cnt == '0);
    assign last_px  = (pix_cnt == PW'(ND - 1));
    // The first word of a frame is tagged before class_reg has captured it
    assign tag      = first_px ? bus.class_in : class_reg;

    sync_fifo_fwft #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_acc),
        .wr_data ({tag, bus.data_in}),
        .rd_en   (rd_acc),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .usedw   (usedw)
    );

    assign {bus.image_class, bus.fifo_data} = rd_data;
    assign bus.fifo_empty = empty;
    assign bus.fifo_usedw = usedw;
    assign bus.ready_out  = (usedw < UW'(DEPTH - AFULL_MARGIN));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_cnt    <= '0;
            img_cnt    <= '0;
            class_reg  <= '0;
            frame_done <= 1'b0;
            all_done   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= wr_acc & last_px;
            if (bus.data_valid_in & ~wr_acc) overflow <= 1'b1;
            if (wr_acc) begin
                if (first_px) class_reg <= bus.class_in;
                if (last_px) begin
                    pix_cnt <= '0;
                    if (img_cnt != IW'(NUM_IMG)) img_cnt <= img_cnt + 1'b1;
                    if (img_cnt == IW'(NUM_IMG - 1)) all_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_collector_fifo.sv
// Scoreboard bench: default-size collector (A) and a 4x4, 2-frame one (B).
module tb_output_collector_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, rstn_b;
    logic fd_a, ad_a, ov_a;
    logic fd_b, ad_b, ov_b;

    output_collector_fifo_if ia ();
    output_collector_fifo_if ib ();

    output_collector_fifo dut_a (
        .clk        (clk),
        .resetn     (rstn_a),
        .bus        (ia.slave),
        .frame_done (fd_a),
        .all_done   (ad_a),
        .overflow   (ov_a)
    );

    output_collector_fifo #(
        .WIDTH   (4),
        .HEIGHT  (4),
        .NUM_IMG (2)
    ) dut_b (
        .clk        (clk),
        .resetn     (rstn_b),
        .bus        (ib.slave),
        .frame_done (fd_b),
        .all_done   (ad_b),
        .overflow   (ov_b)
    );

    int nchk = 0;
    int nerr = 0;

    logic [35:0] sa[$];
    logic [35:0] sb[$];
    int          pa, pb, imb;
    logic [3:0]  cra, crb;
    bit          ova, ovb, adb, fdb;

    task automatic step_a(input logic v, input logic [31:0] d,
                          input logic [3:0] c, input logic r);
        bit rd, wr;
        logic [3:0] tg;
        ia.data_valid_in = v;
        ia.data_in       = d;
        ia.class_in      = c;
        ia.fifo_rdreq    = r;
        rd = r && sa.size() != 0;
        wr = v && (sa.size() < 64 || rd);
        tg = (pa == 0) ? c : cra;
        if (v && !wr) ova = 1;
        if (wr) begin
            if (pa == 0) cra = c;
            pa = (pa == 3135) ? 0 : pa + 1;
        end
        if (rd) void'(sa.pop_front());
        if (wr) sa.push_back({tg, d});
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [31:0] d,
                          input logic [3:0] c, input logic r);
        bit rd, wr;
        logic [3:0] tg;
        ib.data_valid_in = v;
        ib.data_in       = d;
        ib.class_in      = c;
        ib.fifo_rdreq    = r;
        rd = r && sb.size() != 0;
        wr = v && !adb && (sb.size() < 64 || rd);
        tg = (pb == 0) ? c : crb;
        fdb = 0;
        if (v && !wr) ovb = 1;
        if (wr) begin
            if (pb == 0) crb = c;
            if (pb == 15) begin
                pb  = 0;
                fdb = 1;
                imb++;
                if (imb == 2) adb = 1;
            end else begin
                pb++;
            end
        end
        if (rd) void'(sb.pop_front());
        if (wr) sb.push_back({tg, d});
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        sa.delete();
        pa = 0; cra = 0; ova = 0;
    endtask

    task automatic clr_b();
        sb.delete();
        pb = 0; imb = 0; crb = 0; ovb = 0; adb = 0; fdb = 0;
    endtask

    task automatic reset_a();
        rstn_a = 0;
        ia.data_valid_in = 0;
        ia.fifo_rdreq = 0;
        clr_a();
        @(posedge clk);
        #1;
        rstn_a = 1;
    endtask

    task automatic test_reset();
        rstn_a = 0; rstn_b = 0;
        ia.data_in = 0; ia.data_valid_in = 0; ia.class_in = 0; ia.fifo_rdreq = 0;
        ib.data_in = 0; ib.data_valid_in = 0; ib.class_in = 0; ib.fifo_rdreq = 0;
        clr_a(); clr_b();
        repeat (2) @(posedge clk);
        #1;
        nchk++; if (ia.fifo_empty !== 1'b1) begin nerr++; $display("FAIL rst empty: got %b want 1", ia.fifo_empty); end
        nchk++; if (ia.ready_out !== 1'b1) begin nerr++; $display("FAIL rst ready: got %b want 1", ia.ready_out); end
        nchk++; if (ia.fifo_usedw !== 7'd0) begin nerr++; $display("FAIL rst usedw: got %0d want 0", ia.fifo_usedw); end
        nchk++; if (fd_a !== 1'b0) begin nerr++; $display("FAIL rst frame_done: got %b want 0", fd_a); end
        nchk++; if (ad_a !== 1'b0) begin nerr++; $display("FAIL rst all_done: got %b want 0", ad_a); end
        nchk++; if (ov_a !== 1'b0) begin nerr++; $display("FAIL rst overflow: got %b want 0", ov_a); end
        nchk++; if (ia.fifo_data !== 32'h0) begin nerr++; $display("FAIL rst data: got %h want 0", ia.fifo_data); end
        nchk++; if (ia.image_class !== 4'h0) begin nerr++; $display("FAIL rst class: got %h want 0", ia.image_class); end
        nchk++; if (ib.fifo_empty !== 1'b1) begin nerr++; $display("FAIL rst b empty: got %b want 1", ib.fifo_empty); end
        nchk++; if (ad_b !== 1'b0) begin nerr++; $display("FAIL rst b all_done: got %b want 0", ad_b); end
        rstn_a = 1; rstn_b = 1;
    endtask

    task automatic test_basic();
        nchk++; if (ia.fifo_empty !== 1'b1) begin nerr++; $display("FAIL basic pre empty: got %b want 1", ia.fifo_empty); end
        step_a(1, 32'hA, 4'd2, 0);
        nchk++; if (ia.fifo_empty !== 1'b0) begin nerr++; $display("FAIL basic empty fall: got %b want 0", ia.fifo_empty); end
        step_a(1, 32'hB, 4'd7, 0);
        step_a(1, 32'hC, 4'd7, 0);
        nchk++; if (ia.fifo_usedw !== 7'd3) begin nerr++; $display("FAIL basic usedw: got %0d want 3", ia.fifo_usedw); end
        nchk++; if (ia.fifo_data !== 32'hA) begin nerr++; $display("FAIL basic head: got %h want a", ia.fifo_data); end
        nchk++; if (ia.image_class !== 4'd2) begin nerr++; $display("FAIL basic class: got %0d want 2", ia.image_class); end
        nchk++; if ({ia.image_class, ia.fifo_data} !== sa[0]) begin nerr++; $display("FAIL basic sb head: got %h want %h", {ia.image_class, ia.fifo_data}, sa[0]); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 3; i < 64; i++) begin
            step_a(1, 32'h100 + i, 4'd7, 0);
            nchk++; if (ia.ready_out !== (sa.size() < 60)) begin nerr++; $display("FAIL fill ready at %0d: got %b want %b", sa.size(), ia.ready_out, sa.size() < 60); end
        end
        nchk++; if (ia.fifo_usedw !== 7'd64) begin nerr++; $display("FAIL fill usedw: got %0d want 64", ia.fifo_usedw); end
        nchk++; if (ov_a !== 1'b0) begin nerr++; $display("FAIL fill early overflow: got %b want 0", ov_a); end
        step_a(1, 32'hDEAD, 4'd7, 0);
        nchk++; if (ov_a !== ova) begin nerr++; $display("FAIL extra overflow: got %b want %b", ov_a, ova); end
        nchk++; if (ia.fifo_usedw !== 7'd64) begin nerr++; $display("FAIL extra usedw: got %0d want 64", ia.fifo_usedw); end
        nchk++; if (ia.fifo_data !== 32'hA) begin nerr++; $display("FAIL extra head: got %h want a", ia.fifo_data); end
    endtask

    task automatic test_full_rw();
        reset_a();
        for (int i = 0; i < 64; i++)
            step_a(1, 32'h1000 + i, (i == 0) ? 4'd4 : 4'd9, 0);
        nchk++; if (ia.fifo_usedw !== 7'd64) begin nerr++; $display("FAIL fullrw usedw pre: got %0d want 64", ia.fifo_usedw); end
        nchk++; if ({ia.image_class, ia.fifo_data} !== sa[0]) begin nerr++; $display("FAIL fullrw head: got %h want %h", {ia.image_class, ia.fifo_data}, sa[0]); end
        step_a(1, 32'h7777, 4'd9, 1);
        nchk++; if (ia.fifo_usedw !== 7'd64) begin nerr++; $display("FAIL fullrw usedw: got %0d want 64", ia.fifo_usedw); end
        nchk++; if (ov_a !== 1'b0) begin nerr++; $display("FAIL fullrw overflow: got %b want 0", ov_a); end
        for (int i = 0; i < 64; i++) begin
            if (sa.size() != 0) begin
                nchk++; if ({ia.image_class, ia.fifo_data} !== sa[0]) begin nerr++; $display("FAIL drain %0d: got %h want %h", i, {ia.image_class, ia.fifo_data}, sa[0]); end
            end
            step_a(0, 0, 0, 1);
        end
        nchk++; if (ia.fifo_empty !== 1'b1) begin nerr++; $display("FAIL drain empty: got %b want 1", ia.fifo_empty); end
    endtask

    task automatic test_empty_read();
        repeat (5) begin
            step_a(0, 0, 0, 1);
            nchk++; if (ia.fifo_empty !== 1'b1 || ia.fifo_usedw !== 7'd0) begin nerr++; $display("FAIL emptyrd state: got %b/%0d want 1/0", ia.fifo_empty, ia.fifo_usedw); end
        end
        nchk++; if (ov_a !== 1'b0) begin nerr++; $display("FAIL emptyrd overflow: got %b want 0", ov_a); end
        step_a(1, 32'h55, 4'd3, 1);
        nchk++; if (ia.fifo_empty !== 1'b0) begin nerr++; $display("FAIL emptyrd fall: got %b want 0", ia.fifo_empty); end
        nchk++; if (ia.fifo_data !== 32'h55) begin nerr++; $display("FAIL emptyrd head: got %h want 55", ia.fifo_data); end
        nchk++; if ({ia.image_class, ia.fifo_data} !== sa[0]) begin nerr++; $display("FAIL emptyrd sb: got %h want %h", {ia.image_class, ia.fifo_data}, sa[0]); end
        step_a(0, 0, 0, 1);
        nchk++; if (ia.fifo_empty !== 1'b1) begin nerr++; $display("FAIL emptyrd pop: got %b want 1", ia.fifo_empty); end
    endtask

    task automatic test_frames();
        logic [3:0] c;
        for (int k = 1; k <= 33; k++) begin
            if (sb.size() != 0) begin
                nchk++; if ({ib.image_class, ib.fifo_data} !== sb[0]) begin nerr++; $display("FAIL frames head k=%0d: got %h want %h", k, {ib.image_class, ib.fifo_data}, sb[0]); end
            end
            c = (k == 1) ? 4'd1 : (k == 17) ? 4'd3 : 4'd6;
            step_b(1, 32'h2000 + k, c, 1);
            nchk++; if (fd_b !== fdb) begin nerr++; $display("FAIL frame_done k=%0d: got %b want %b", k, fd_b, fdb); end
            nchk++; if (ad_b !== adb) begin nerr++; $display("FAIL all_done k=%0d: got %b want %b", k, ad_b, adb); end
        end
        nchk++; if (ov_b !== ovb) begin nerr++; $display("FAIL frames overflow: got %b want %b", ov_b, ovb); end
        nchk++; if (ib.fifo_empty !== 1'b1) begin nerr++; $display("FAIL frames empty: got %b want 1", ib.fifo_empty); end
    endtask

    task automatic test_reset_midframe();
        rstn_b = 0;
        ib.data_valid_in = 0;
        ib.fifo_rdreq = 0;
        clr_b();
        @(posedge clk);
        #1;
        rstn_b = 1;
        for (int k = 1; k <= 7; k++) step_b(1, 32'h3000 + k, (k == 1) ? 4'd2 : 4'd6, 0);
        repeat (2) begin
            nchk++; if ({ib.image_class, ib.fifo_data} !== sb[0]) begin nerr++; $display("FAIL mid head: got %h want %h", {ib.image_class, ib.fifo_data}, sb[0]); end
            step_b(0, 0, 0, 1);
        end
        nchk++; if (ib.fifo_usedw !== 7'd5) begin nerr++; $display("FAIL mid usedw: got %0d want 5", ib.fifo_usedw); end
        ib.fifo_rdreq = 0;
        #2 rstn_b = 0;
        #1;
        nchk++; if (ib.fifo_empty !== 1'b1 || ib.fifo_usedw !== 7'd0) begin nerr++; $display("FAIL mid async rst: got %b/%0d want 1/0", ib.fifo_empty, ib.fifo_usedw); end
        clr_b();
        @(posedge clk);
        #1;
        rstn_b = 1;
        for (int k = 1; k <= 16; k++) begin
            step_b(1, 32'h4000 + k, (k == 1) ? 4'd5 : 4'd6, 0);
            if (k == 1) begin
                nchk++; if (ib.image_class !== 4'd5) begin nerr++; $display("FAIL mid class: got %0d want 5", ib.image_class); end
            end
            nchk++; if (fd_b !== fdb) begin nerr++; $display("FAIL mid frame_done k=%0d: got %b want %b", k, fd_b, fdb); end
        end
        nchk++; if (ad_b !== 1'b0) begin nerr++; $display("FAIL mid all_done: got %b want 0", ad_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_rw();
        test_empty_read();
        test_frames();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
